// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioning stage and the watering FSM.
// - light_phase_t : 2-bit day-phase code carried on l_thresh
// - clamp8        : saturates an integer threshold into the 0..255 ADC range
package sensor_pkg;

  typedef enum logic [1:0] {
    LP_NIGHT = 2'b00,
    LP_DAWN  = 2'b01,
    LP_DAY   = 2'b10,
    LP_DUSK  = 2'b11
  } light_phase_t;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0)
      return 8'd0;
    else if (v > 255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/sensor_cond_if.sv
// Sample/result bundle between the ADC front end, the conditioning stage and
// the watering FSM.
//   sample_valid, m_raw, l_raw          : raw sample strobe and data
//   m_sense, l_sense, l_thresh          : conditioned outputs
//   sense_valid                         : pulse when outputs come from a full window
// master = sample producer / result consumer, slave = sensor_cond.
interface sensor_cond_if;
  logic       sample_valid;
  logic [7:0] m_raw;
  logic [7:0] l_raw;
  logic [7:0] m_sense;
  logic [7:0] l_sense;
  logic [1:0] l_thresh;
  logic       sense_valid;

  modport master (
    output sample_valid, m_raw, l_raw,
    input  m_sense, l_sense, l_thresh, sense_valid
  );

  modport slave (
    input  sample_valid, m_raw, l_raw,
    output m_sense, l_sense, l_thresh, sense_valid
  );
endinterface

// File: rtl/sensor_cond_moving_avg.sv
// Boxcar moving average over 2**AVG_LOG2 samples.
// Ports:
//   clk, rst  : clock, async active-high reset
//   in_valid  : accept din this cycle
//   din       : new sample
//   avg       : (sum + din - oldest) >> AVG_LOG2, valid in the in_valid cycle
//   full      : window holds N samples once this sample is accepted
// The caller registers avg; this block owns ring buffer, sum and fill count.
module moving_avg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] avg,
  output logic             full
);

  localparam int unsigned N   = 1 << AVG_LOG2;
  localparam int unsigned NM1 = N - 1;
  localparam int unsigned SW  = WIDTH + AVG_LOG2;
  localparam int unsigned ONE = 1;

  localparam logic [AVG_LOG2:0]   FILL_MAX  = N[AVG_LOG2:0];
  localparam logic [AVG_LOG2:0]   FILL_LAST = NM1[AVG_LOG2:0];
  localparam logic [AVG_LOG2:0]   FILL_ONE  = ONE[AVG_LOG2:0];
  localparam logic [AVG_LOG2-1:0] PTR_ONE   = ONE[AVG_LOG2-1:0];

  logic [WIDTH-1:0]    ring [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       sum_next;
  logic [WIDTH-1:0]    oldest;
  logic                full_q;

  assign full_q = (fill == FILL_MAX);

  // Intermediate sum + din may wrap past SW bits; the subtraction brings it
  // back, and the true result always fits since it is at most N * (2**WIDTH-1).
  always_comb begin
    oldest   = full_q ? ring[wr_ptr] : '0;
    sum_next = sum + SW'(din) - SW'(oldest);
    avg      = WIDTH'(sum_next >> AVG_LOG2);
    full     = full_q || (fill == FILL_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++)
        ring[i] <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
    end else if (in_valid) begin
      ring[wr_ptr] <= din;
      wr_ptr       <= wr_ptr + PTR_ONE;
      sum          <= sum_next;
      if (!full_q)
        fill <= fill + FILL_ONE;
    end
  end

endmodule

// File: rtl/sensor_cond.sv
// Sensor conditioning: moving average of moisture and light samples plus a
// debounced, hysteretic light-phase classifier feeding the watering FSM.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : sensor_cond_if.slave
//          in : sample_valid, m_raw, l_raw
//          out: m_sense, l_sense (averages), l_thresh (light phase),
//               sense_valid (pulse, outputs from a full window)
// All outputs are registered and update on the edge that accepts a sample.
module sensor_cond
  import sensor_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [7:0]  DAWN_LO  = 8'd40,
  parameter logic [7:0]  DAWN_HI  = 8'd120,
  parameter logic [7:0]  HYST     = 8'd8,
  parameter logic [3:0]  DEBOUNCE = 4'd8
) (
  input  logic          clk,
  input  logic          rst,
  sensor_cond_if.slave  bus
);

  localparam logic [7:0] UP_LO = clamp8(int'(DAWN_LO) + int'(HYST));
  localparam logic [7:0] DN_LO = clamp8(int'(DAWN_LO) - int'(HYST));
  localparam logic [7:0] UP_HI = clamp8(int'(DAWN_HI) + int'(HYST));
  localparam logic [7:0] DN_HI = clamp8(int'(DAWN_HI) - int'(HYST));

  if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("sensor_cond: AVG_LOG2 must be in 1..4");
  end
  if (DEBOUNCE == 4'd0) begin : g_bad_debounce
    $error("sensor_cond: DEBOUNCE must be in 1..15");
  end
  // Keeps the DAWN up/down and DUSK up/down exits mutually exclusive.
  if (!(UP_LO < DN_HI)) begin : g_bad_thresh
    $error("sensor_cond: thresholds require UP_LO < DN_HI");
  end

  logic [7:0]   m_avg;
  logic [7:0]   l_avg;
  logic         m_full;
  logic         l_full;
  logic         sense_edge;
  light_phase_t phase;
  light_phase_t exit_to;
  logic         exit_hit;
  logic [3:0]   db_cnt;

  moving_avg #(.WIDTH(8), .AVG_LOG2(AVG_LOG2)) u_m_avg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.sample_valid),
    .din      (bus.m_raw),
    .avg      (m_avg),
    .full     (m_full)
  );

  moving_avg #(.WIDTH(8), .AVG_LOG2(AVG_LOG2)) u_l_avg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.sample_valid),
    .din      (bus.l_raw),
    .avg      (l_avg),
    .full     (l_full)
  );

  assign sense_edge = bus.sample_valid && m_full && l_full;

  // Exit condition of the current phase, judged on the freshly averaged light.
  always_comb begin
    exit_hit = 1'b0;
    exit_to  = phase;
    unique case (phase)
      LP_NIGHT: begin
        if (l_avg >= UP_LO) begin
          exit_hit = 1'b1;
          exit_to  = LP_DAWN;
        end
      end
      LP_DAWN: begin
        if (l_avg >= UP_HI) begin
          exit_hit = 1'b1;
          exit_to  = LP_DAY;
        end else if (l_avg < DN_LO) begin
          exit_hit = 1'b1;
          exit_to  = LP_NIGHT;
        end
      end
      LP_DAY: begin
        if (l_avg < DN_HI) begin
          exit_hit = 1'b1;
          exit_to  = LP_DUSK;
        end
      end
      LP_DUSK: begin
        if (l_avg < DN_LO) begin
          exit_hit = 1'b1;
          exit_to  = LP_NIGHT;
        end else if (l_avg >= UP_HI) begin
          exit_hit = 1'b1;
          exit_to  = LP_DAY;
        end
      end
      default: begin
        exit_hit = 1'b0;
        exit_to  = LP_NIGHT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_sense     <= '0;
      bus.l_sense     <= '0;
      bus.sense_valid <= 1'b0;
      phase           <= LP_NIGHT;
      db_cnt          <= '0;
    end else begin
      bus.sense_valid <= 1'b0;
      if (bus.sample_valid) begin
        bus.m_sense <= m_avg;
        bus.l_sense <= l_avg;
      end
      if (sense_edge) begin
        bus.sense_valid <= 1'b1;
        if (exit_hit) begin
          // Count hits DEBOUNCE on this edge: move and restart the count.
          if (db_cnt == DEBOUNCE - 4'd1) begin
            phase  <= exit_to;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 4'd1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign bus.l_thresh = phase;

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond with a queue-based reference model checked
// every cycle, plus literal expectations for the worked examples.
module tb_sensor_cond;

  localparam int N     = 4;
  localparam int LOG2N = 2;
  localparam int DEB   = 8;
  // DAWN_LO=40, DAWN_HI=120, HYST=8
  localparam int UP_LO = 48;
  localparam int DN_LO = 32;
  localparam int UP_HI = 128;
  localparam int DN_HI = 112;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sensor_cond_if bus ();

  sensor_cond #(
    .AVG_LOG2 (2),
    .DAWN_LO  (8'd40),
    .DAWN_HI  (8'd120),
    .HYST     (8'd8),
    .DEBOUNCE (4'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mq[$];
  int lq[$];
  int hist[$];
  int exp_m, exp_l, exp_t, exp_sv;

  function automatic int qavg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / N;
  endfunction

  // Phase the light level argues for from phase ph (ph itself if no exit).
  function automatic int target(input int ph, input int v);
    case (ph)
      0: return (v >= UP_LO) ? 1 : 0;
      1: return (v >= UP_HI) ? 2 : ((v < DN_LO) ? 0 : 1);
      2: return (v < DN_HI) ? 3 : 2;
      default: return (v < DN_LO) ? 0 : ((v >= UP_HI) ? 2 : 3);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); lq.delete(); hist.delete();
      exp_m = 0; exp_l = 0; exp_t = 0; exp_sv = 0;
    end else begin
      exp_sv = 0;
      if (bus.sample_valid) begin
        mq.push_back(int'(bus.m_raw));
        lq.push_back(int'(bus.l_raw));
        if (mq.size() > N) void'(mq.pop_front());
        if (lq.size() > N) void'(lq.pop_front());
        exp_m = qavg(mq);
        exp_l = qavg(lq);
        if (mq.size() == N) begin
          bit all_exit;
          exp_sv = 1;
          hist.push_back(target(exp_t, exp_l));
          if (hist.size() > DEB) void'(hist.pop_front());
          // Move once the last DEB full-window samples all argued for an exit.
          all_exit = (hist.size() == DEB);
          foreach (hist[i]) if (hist[i] == exp_t) all_exit = 0;
          if (all_exit) begin
            exp_t = hist[DEB-1];
            hist.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  bit rec    = 0;
  int seq[$];
  int last_t = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_sense",     bus.m_sense,     exp_m);
      chk("l_sense",     bus.l_sense,     exp_l);
      chk("l_thresh",    bus.l_thresh,    exp_t);
      chk("sense_valid", bus.sense_valid, exp_sv);
    end
    if (rec && int'(bus.l_thresh) != last_t) begin
      last_t = int'(bus.l_thresh);
      seq.push_back(last_t);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_m_sense",  bus.m_sense,     0);
    chk("rst_l_sense",  bus.l_sense,     0);
    chk("rst_l_thresh", bus.l_thresh,    0);
    chk("rst_sv",       bus.sense_valid, 0);
    @(posedge clk); #4;
    rst = 1'b0;
  endtask

  // One sample followed by a gap; returns just after the accepting edge.
  task automatic push(input int m, input int l);
    @(posedge clk); #2;
    bus.sample_valid = 1'b1;
    bus.m_raw = 8'(m);
    bus.l_raw = 8'(l);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  // Back-to-back strobe; caller ends the burst with idle().
  task automatic strobe(input int m, input int l);
    @(posedge clk); #2;
    bus.sample_valid = 1'b1;
    bus.m_raw = 8'(m);
    bus.l_raw = 8'(l);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.sample_valid = 1'b0;
    end
  endtask

  int lit_m[4] = '{25, 51, 78, 106};
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.sample_valid = 1'b0;
    bus.m_raw = '0;
    bus.l_raw = '0;
    #1 rst = 1'b1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    // Averaging worked example
    for (int k = 0; k < 4; k++) begin
      push(100 + 4 * k, 0);
      chk("avg_lit", bus.m_sense, lit_m[k]);
      chk("avg_sv_lit", bus.sense_valid, (k == 3) ? 1 : 0);
    end
    push(0, 0);
    chk("avg_5th_lit", bus.m_sense, 81);

    // Debounce into DAWN at exactly UP_LO
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      push(10, 48);
      if (k == 10) chk("db_night_lit", bus.l_thresh, 0);
      if (k == 11) chk("db_dawn_lit",  bus.l_thresh, 1);
    end

    // Dither near DAWN_LO never settles long enough
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) push(20, 48);
      push(20, 30);
    end
    chk("dither_lit", bus.l_thresh, 0);

    // Full day sweep
    do_reset();
    seq.delete();
    seq.push_back(0);
    last_t = 0;
    rec = 1;
    for (int v = 0; v <= 200; v += 4) strobe(v / 2, v);
    for (int k = 0; k < 12; k++) strobe(100, 200);
    for (int v = 200; v >= 0; v -= 4) strobe(v / 2, v);
    for (int k = 0; k < 12; k++) strobe(0, 0);
    idle(3);
    rec = 0;
    chk("sweep_len", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("sweep_seq", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

    // Reset mid-window
    do_reset();
    push(60, 70);
    push(80, 90);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_m",  bus.m_sense,     0);
    chk("mid_rst_l",  bus.l_sense,     0);
    chk("mid_rst_t",  bus.l_thresh,    0);
    chk("mid_rst_sv", bus.sense_valid, 0);
    #3 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(40, 40);
      chk("refill_sv_lit", bus.sense_valid, (k == 3) ? 1 : 0);
    end

    // Random gaps between strobes
    do_reset();
    for (int k = 0; k < 40; k++) begin
      idle($urandom_range(0, 5));
      strobe($urandom_range(0, 255), (k < 20) ? $urandom_range(40, 255) : $urandom_range(0, 140));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
